// File: rtl/vdp_vram_arb.sv
// VRAM port arbiter for the vdp99: CPU address latch, auto-increment address,
// read-ahead buffer and one-deep CPU op slot sharing a synchronous VRAM with DMA.
module vdp_vram_arb #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  pxclk,
  input  logic                  reset,
  input  logic                  wr_tick,
  input  logic                  rd_tick,
  input  logic                  mode,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  input  logic                  dma_req,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [7:0]            dma_data,
  output logic                  dma_valid,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_re,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  output logic                  cpu_busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_RDWAIT} state_t;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              lo_q, lo_d;
  logic                    latch_q, latch_d;
  logic [7:0]              rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0]   op_addr_q, op_addr_d;
  logic [7:0]              op_data_q, op_data_d;
  logic                    op_kind_q, op_kind_d;
  logic                    overrun_q, overrun_d;
  logic                    dma_valid_q;
  logic                    cpu_rd_q;

  logic                    ctrl_wr, data_wr, ctrl_rd, data_rd;
  logic                    prefetch, queue_op;
  logic                    cpu_re, cpu_we;
  logic [ADDR_WIDTH-1:0]   setup_addr;

  // A simultaneous read strobe is ignored in favour of the write.
  assign ctrl_wr    = wr_tick & mode;
  assign data_wr    = wr_tick & ~mode;
  assign ctrl_rd    = rd_tick & ~wr_tick & mode;
  assign data_rd    = rd_tick & ~wr_tick & ~mode;
  assign setup_addr = ADDR_WIDTH'({din[5:0], lo_q});
  assign prefetch   = ctrl_wr & latch_q & ~din[7] & ~din[6];
  assign queue_op   = prefetch | data_wr | data_rd;

  always_comb begin
    state_d = state_q;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    case (state_q)
      ST_PEND: begin
        if (!dma_req) begin
          if (op_kind_q == OP_WRITE) begin
            cpu_we  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cpu_re  = 1'b1;
            state_d = ST_RDWAIT;
          end
        end
      end
      ST_RDWAIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (queue_op) state_d = ST_PEND;
  end

  always_comb begin
    addr_d    = addr_q;
    lo_d      = lo_q;
    latch_d   = latch_q;
    rbuf_d    = rbuf_q;
    op_addr_d = op_addr_q;
    op_data_d = op_data_q;
    op_kind_d = op_kind_q;
    overrun_d = overrun_q | (queue_op & cpu_busy);
    // A CPU read issued last cycle lands here even if a newer op replaced it.
    if (cpu_rd_q) rbuf_d = vram_rdata;
    if (ctrl_wr) begin
      if (!latch_q) begin
        lo_d    = din;
        latch_d = 1'b1;
      end else begin
        latch_d = 1'b0;
        if (!din[7]) addr_d = din[6] ? setup_addr : setup_addr + ADDR_WIDTH'(1);
      end
    end else if (data_wr) begin
      latch_d = 1'b0;
      rbuf_d  = din;
      addr_d  = addr_q + ADDR_WIDTH'(1);
    end else if (ctrl_rd || data_rd) begin
      latch_d = 1'b0;
      if (data_rd) addr_d = addr_q + ADDR_WIDTH'(1);
    end
    if (queue_op) begin
      op_addr_d = prefetch ? setup_addr : addr_q;
      op_kind_d = data_wr ? OP_WRITE : OP_READ;
      if (data_wr) op_data_d = din;
    end
  end

  always_ff @(posedge pxclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      lo_q        <= '0;
      latch_q     <= 1'b0;
      rbuf_q      <= '0;
      op_addr_q   <= '0;
      op_data_q   <= '0;
      op_kind_q   <= OP_READ;
      overrun_q   <= 1'b0;
      dma_valid_q <= 1'b0;
      cpu_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lo_q        <= lo_d;
      latch_q     <= latch_d;
      rbuf_q      <= rbuf_d;
      op_addr_q   <= op_addr_d;
      op_data_q   <= op_data_d;
      op_kind_q   <= op_kind_d;
      overrun_q   <= overrun_d;
      dma_valid_q <= dma_req;
      cpu_rd_q    <= cpu_re;
    end
  end

  assign dout       = rbuf_q;
  assign dma_valid  = dma_valid_q;
  assign dma_data   = dma_valid_q ? vram_rdata : 8'h00;
  assign vram_re    = dma_req | cpu_re;
  assign vram_we    = cpu_we;
  assign vram_wdata = op_data_q;
  assign vram_addr  = (!dma_req && state_q == ST_PEND) ? op_addr_q : dma_addr;
  assign cpu_busy   = (state_q != ST_IDLE);
  assign overrun    = overrun_q;

endmodule
